// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT control FSM.
// Ports: clk, rst_n (async, active low); mem_rdata/mem_ready in, and
// mem_req/mem_we/mem_addr out for the memory bus; psr in (status flags C,P,E,N,Z);
// pc/ir out (architectural registers); alu_go/reg_we out (one-cycle strobes);
// halted/illegal out (status).
// Optional: CPU_CTRL_ILLEGAL_TRAP_EN makes opcodes 1010-1111 trap to HALT.
// Without it they decode as NOP and illegal is tied to 0.
`timescale 1ns/1ps
module cpu_ctrl #(
    parameter int BUSW  = 32,
    parameter int MINDW = 12,
    parameter int PSRW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUSW-1:0]  mem_rdata,
    input  logic             mem_ready,
    input  logic [PSRW-1:0]  psr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [MINDW-1:0] mem_addr,
    output logic [MINDW-1:0] pc,
    output logic [BUSW-1:0]  ir,
    output logic             alu_go,
    output logic             reg_we,
    output logic             halted,
    output logic             illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [3:0] OP_NOP = 4'b0000, OP_LD = 4'b0001, OP_STR = 4'b0010,
                           OP_BRA = 4'b0011, OP_XOR = 4'b0100, OP_ADD = 4'b0101,
                           OP_ROT = 4'b0110, OP_SHF = 4'b0111, OP_HLT = 4'b1000,
                           OP_CMP = 4'b1001;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    state_t state, nxt;
    logic [3:0] op, cc;
    logic [MINDW-1:0] src, dst;
    logic taken;
    assign op  = ir[31:28];
    assign cc  = ir[27:24];
    assign src = ir[12 +: MINDW];
    assign dst = ir[MINDW-1:0];
    always_comb begin
        taken = 1'b0;
        case (cc)
            4'b0000: taken = 1'b1;
            4'b0001: taken = psr[1];
            4'b0010: taken = psr[2];
            4'b0011: taken = psr[0];
            4'b0100: taken = psr[3];
            4'b0101: taken = psr[4];
            4'b0110: taken = !psr[0];
            4'b0111: taken = !psr[3] && !psr[4];
            default: taken = 1'b0;
        endcase
    end
    always_comb begin
        nxt = state;
        case (state)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE:
                case (op)
                    OP_NOP, OP_BRA:                         nxt = FETCH;
                    OP_HLT:                                 nxt = HALT;
                    OP_LD, OP_STR:                          nxt = MEM;
                    OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: nxt = EXEC;
                    default:                                nxt = TRAP ? HALT : FETCH;
                endcase
            MEM:    nxt = !mem_ready ? MEM : (op == OP_LD) ? WB : FETCH;
            EXEC:   nxt = (op == OP_CMP) ? FETCH : WB;
            WB:     nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end
    // mem_req is gated by rst_n so a pending access is dropped the moment reset asserts.
    always_comb begin
        mem_req  = rst_n && (state == FETCH || state == MEM);
        mem_we   = rst_n && state == MEM && op == OP_STR;
        mem_addr = (state == FETCH) ? pc : (state == MEM) ? ((op == OP_STR) ? dst : src) : '0;
        alu_go   = state == EXEC;
        reg_we   = state == WB;
        halted   = state == HALT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == FETCH && mem_ready) begin
                ir <= mem_rdata;
                pc <= pc + MINDW'(1);
            end else if (state == DECODE && op == OP_BRA && taken) begin
                pc <= dst;
            end
        end
    end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (state == DECODE && op >= 4'b1010)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: randomized instruction-level check of cpu_ctrl against a latency/branch model.
`timescale 1ns/1ps
module tb_cpu_ctrl;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [4:0]  psr = '0;
    logic        mem_req, mem_we, alu_go, reg_we, halted, illegal;
    logic [11:0] mem_addr, pc;
    logic [31:0] ir;
    logic [11:0] mpc = '0;
    logic        mill = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .psr(psr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .pc(pc), .ir(ir),
        .alu_go(alu_go), .reg_we(reg_we), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, sample mid-cycle, advance to just past the edge.
    // Address and write qualifier only matter while a request is up.
    task automatic cyc(input string tag, input logic req, input logic we, input logic [11:0] addr,
                       input logic alu, input logic rwe, input logic hlt, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, 64'({mem_req, mem_req & mem_we, mem_req ? mem_addr : 12'h0,
                        alu_go, reg_we, halted, illegal, pc}),
                   64'({req, we, addr, alu, rwe, hlt, mill, mpc}));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("reset", 64'({mem_req, mem_we, mem_addr, pc, ir, alu_go, reg_we, halted, illegal}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mpc = '0;
        mill = 1'b0;
    endtask

    // Execute one instruction; mw<0 means random wait states, otherwise exact MEM waits.
    task automatic run(input logic [31:0] w, input logic [4:0] p, input int mw);
        logic [3:0] op, cc;
        int k;
        bit tk;
        string t;
        op = w[31:28];
        cc = w[27:24];
        psr = p;
        mem_rdata = w;
        k = (mw < 0) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i <= k; i++) cyc("fetch", 1, 0, mpc, 0, 0, 0, i == k);
        mem_rdata = $urandom;
        mpc = mpc + 12'd1;
        check("ir", 64'(ir), 64'(w));
        cyc("decode", 0, 0, 12'h0, 0, 0, 0, 1'($urandom));
        if (op == 4'h3) begin
            tk = cc == 0 || (cc == 1 && p[1]) || (cc == 2 && p[2]) || (cc == 3 && p[0]) ||
                 (cc == 4 && p[3]) || (cc == 5 && p[4]) || (cc == 6 && !p[0]) ||
                 (cc == 7 && !p[3] && !p[4]);
            if (tk) mpc = w[11:0];
        end else if (op == 4'h1 || op == 4'h2) begin
            k = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
            t = (op == 4'h1) ? "ld_mem" : "st_mem";
            for (int i = 0; i <= k; i++)
                cyc(t, 1, op == 4'h2, (op == 4'h1) ? w[23:12] : w[11:0], 0, 0, 0, i == k);
            if (op == 4'h1) cyc("ld_wb", 0, 0, 12'h0, 0, 1, 0, 1'($urandom));
        end else if (op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h9}) begin
            cyc("exec", 0, 0, 12'h0, 1, 0, 0, 1'($urandom));
            if (op != 4'h9) cyc("wb", 0, 0, 12'h0, 0, 1, 0, 1'($urandom));
        end else if (op == 4'h8 || (TRAP && op >= 4'hA)) begin
            if (op != 4'h8) mill = 1'b1;
            repeat (3) cyc("halt", 0, 0, 12'h0, 0, 0, 1, 1'($urandom));
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [3:0] op;
        w = $urandom;
        op = 4'($urandom_range(0, 15));
        if (op == 4'h8 || (TRAP && op >= 4'hA)) op = 4'h0;
        w[31:28] = op;
        return w;
    endfunction

    initial begin
        do_reset();
        // three NOPs then HLT: pc 1,2,3,4, halted after 8 cycles
        repeat (3) run(32'h0000_0000, 5'h0, 0);
        run(32'h8000_0000, 5'h0, 0);
        do_reset();
        run(32'h5000_1003, 5'h0, 0);
        run(32'h3500_0100, 5'b10000, 0);
        run(32'h3500_0200, 5'b00000, 0);
        run(32'h1002_0000, 5'h0, 3);
        run(32'h3000_0FFF, 5'h0, 0);
        run(32'h0000_0000, 5'h0, 0);
        check("wrap", 64'(pc), 64'h0);
        for (int n = 0; n < 400; n++) run(rnd_instr(), 5'($urandom), -1);
        run(32'h8000_0000, 5'($urandom), -1);
        // reset in the middle of a stalled load
        do_reset();
        psr = '0;
        mem_rdata = 32'h1002_0000;
        cyc("fetch", 1, 0, 12'h0, 0, 0, 0, 1);
        mpc = 12'd1;
        cyc("decode", 0, 0, 12'h0, 0, 0, 0, 0);
        cyc("ld_mem", 1, 0, 12'h020, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mem", 64'({mem_req, pc}), 64'h0);
        do_reset();
        run(32'hF000_0000, 5'h0, 0);
        check("ill_op", 64'({halted, illegal}), 64'({TRAP, TRAP}));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameters SHALL be: BUSW, default 32, bus/instruction width; MINDW, default 12, memory index width; PSRW, default 5, status width.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_rdata  input  BUSW  memory read data, valid when mem_ready=1.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 psr  input  PSRW  status flags: [0]=C, [1]=P, [2]=E, [3]=N, [4]=Z.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  write qualifier for mem_req.
REQ-009 mem_addr  output  MINDW  access address.
REQ-010 pc  output  MINDW  program counter.
REQ-011 ir  output  BUSW  instruction register; [31:28]=op, [27]=srctype, [26]=dsttype, [27:24]=cc, [23:12]=src index, [11:0]=dst index.
REQ-012 alu_go  output  1  one-cycle datapath execute strobe.
REQ-013 reg_we  output  1  one-cycle register-file write strobe.
REQ-014 halted  output  1  controller is in HALT.
REQ-015 illegal  output  1  illegal opcode flag (see Configuration).

Function
REQ-016 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-017 In FETCH, mem_req SHALL be 1, mem_we 0 and mem_addr=pc; the FSM SHALL hold until mem_ready.
REQ-018 On mem_ready in FETCH: ir<=mem_rdata, pc<=pc+1 modulo 2**MINDW (4095 wraps to 0), next state DECODE.
REQ-019 DECODE SHALL last one cycle: NOP(0000)->FETCH; HLT(1000)->HALT; BRA(0011)->FETCH; LD(0001)/STR(0010)->MEM; XOR/ADD/ROT/SHF/CMP(0100-0111,1001)->EXEC.
REQ-020 BRA SHALL be taken in DECODE when cc is met: A=0000 always; P=0001 psr[1]; E=0010 psr[2]; C=0011 psr[0]; N=0100 psr[3]; Z=0101 psr[4]; NC=0110 !psr[0]; PO=0111 !psr[3]&!psr[4]; cc 1000-1111 never taken.
REQ-021 A taken branch SHALL load pc<=ir[11:0]; a not-taken branch SHALL leave pc unchanged.
REQ-022 MEM SHALL assert mem_req with mem_addr=ir[23:12] and mem_we=0 for LD, or mem_addr=ir[11:0] and mem_we=1 for STR, holding all three stable until mem_ready.
REQ-023 On mem_ready in MEM: LD->WB; STR->FETCH.
REQ-024 EXEC SHALL pulse alu_go for exactly one cycle, then go to WB, except CMP, which SHALL go to FETCH.
REQ-025 WB SHALL pulse reg_we for exactly one cycle, then go to FETCH.
REQ-026 alu_go and reg_we SHALL never be 1 in the same cycle; mem_req SHALL be 0 outside FETCH and MEM.
REQ-027 Latency with mem_ready=1 throughout SHALL be: NOP/BRA 2 cycles, STR 3, CMP 3, LD 4, XOR/ADD/ROT/SHF 4.
REQ-028 HALT SHALL be terminal: halted=1, all strobes 0, pc and ir frozen; only rst_n exits.
REQ-029 Opcodes 1010-1111 SHALL be treated as NOP unless the feature in REQ-033 is compiled in.

Reset
REQ-030 rst_n=0 SHALL immediately force state=FETCH and pc=0, ir=0, mem_req=0, mem_we=0, mem_addr=0, alu_go=0, reg_we=0, halted=0, illegal=0, regardless of clk.
REQ-031 Reset asserted during a pending MEM or FETCH access SHALL abandon the access; mem_req SHALL drop in the same cycle.
REQ-032 After rst_n deasserts, the first rising clk edge SHALL begin a FETCH from address 0.

Configuration
REQ-033 CPU_CTRL_ILLEGAL_TRAP_EN defined: opcode 1010-1111 in DECODE SHALL set illegal=1 (sticky until reset) and go to HALT.
REQ-034 CPU_CTRL_ILLEGAL_TRAP_EN undefined: the illegal port SHALL remain present and be tied to 0, and such opcodes SHALL behave as NOP.

Verification
REQ-035 Reset, mem_ready=1, memory holds NOP at 0-2 and HLT at 3 -> pc steps 1, 2, 3, 4; halted=1 after 8 cycles; pc frozen at 4.
REQ-036 ADD (0x5000_1003) with mem_ready=1 -> alu_go in cycle 3, reg_we in cycle 4, no mem_req during EXEC or WB.
REQ-037 BRA cc=Z to 0x100 with psr=5'b10000 -> pc=0x100; with psr=0 -> pc=previous+1.
REQ-038 LD src=0x020 with mem_ready held low 3 cycles in MEM -> mem_addr=0x020 and mem_req stable for 4 cycles, then reg_we pulses once.
REQ-039 pc=4095 fetching NOP -> pc wraps to 0; rst_n pulsed low mid-MEM -> mem_req=0 immediately and pc=0.
REQ-040 Opcode 0xF with the macro -> illegal=1, halted=1; without the macro -> treated as NOP, illegal=0.
